// File: rtl/uart_tx_framer_pkg.sv
// Shared encodings for the UART transmit framer.
// State codes and the bit-select values seen by the TX output mux.
package uart_tx_framer_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  localparam logic [1:0] BIT_SEL_START  = 2'b00;
  localparam logic [1:0] BIT_SEL_DATA   = 2'b01;
  localparam logic [1:0] BIT_SEL_PARITY = 2'b10;
  localparam logic [1:0] BIT_SEL_STOP   = 2'b11;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Word handshake into the UART transmit framer.
// The producer drives data/valid, the framer answers with ready.
interface uart_tx_framer_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_parity_gen.sv
// Parity of a data word, even or odd.
// Purely combinational; the framer registers it at accept.
module uart_parity_gen #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = (^data_i) ^ 1'(ODD);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: START, DATA (LSB first), optional PARITY, STOP.
// Bit boundaries follow baud_tick; every output is registered.
module uart_tx_framer
  import uart_tx_framer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  uart_tx_framer_if.slave tx,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] bit_sel
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT =
    CW'(DATA_W - 1);
  localparam logic STOP_LAST =
    1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_EN < 0 || PARITY_EN > 1 ||
      PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_param
    $error("uart_tx_framer: illegal parameters");
  end

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_q, par_d;
  logic              tx_out_q, tx_out_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        sel_q, sel_d;
  logic              par_w;

  uart_parity_gen #(
    .DATA_W (DATA_W),
    .ODD    (PARITY_ODD)
  ) u_par (
    .data_i   (tx.tx_data),
    .parity_o (par_w)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx.tx_valid && ready_q) begin
          shift_d = tx.tx_data;
          par_d   = par_w;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (baud_tick) state_d = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = (PARITY_EN != 0) ?
                         S_PARITY : S_STOP;
            stop_cnt_d = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the next state so they land in the cycle after a tick.
  always_comb begin
    tx_out_d = 1'b1;
    sel_d    = BIT_SEL_STOP;
    unique case (1'b1)
      (state_d == S_START): begin
        tx_out_d = 1'b0;
        sel_d    = BIT_SEL_START;
      end
      (state_d == S_DATA): begin
        tx_out_d = shift_d[0];
        sel_d    = BIT_SEL_DATA;
      end
      (state_d == S_PARITY): begin
        tx_out_d = par_d;
        sel_d    = BIT_SEL_PARITY;
      end
      default: ;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_out_q   <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_q      <= BIT_SEL_STOP;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_out_q   <= tx_out_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sel_q      <= sel_d;
    end
  end

  assign tx.tx_ready = ready_q;
  assign tx_out      = tx_out_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign bit_sel     = sel_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer in 8N1, 8E1, 8O1 and 5N2 forms.
// Expected line bits come from a frame model built from the word itself.
module tb_uart_tx_framer;

  logic clk = 1'b0;
  logic rst_n;
  logic baud_tick = 1'b0;
  int   tick_div = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div  <= (tick_div == 15) ? 0 : tick_div + 1;
    baud_tick <= (tick_div == 14);
  end

  int c_dw[4] = '{8, 8, 8, 5};
  int c_pe[4] = '{0, 1, 1, 0};
  int c_po[4] = '{0, 0, 1, 0};
  int c_sb[4] = '{1, 1, 1, 2};

  logic       vld[4];
  logic [8:0] dat[4];
  logic       rdy[4];
  logic       txo[4];
  logic       bsy[4];
  logic       fd[4];
  logic [1:0] bs[4];

  uart_tx_framer_if #(.DATA_W(8)) if0 ();
  uart_tx_framer_if #(.DATA_W(8)) if1 ();
  uart_tx_framer_if #(.DATA_W(8)) if2 ();
  uart_tx_framer_if #(.DATA_W(5)) if3 ();

  assign if0.tx_valid = vld[0];
  assign if1.tx_valid = vld[1];
  assign if2.tx_valid = vld[2];
  assign if3.tx_valid = vld[3];
  assign if0.tx_data  = dat[0][7:0];
  assign if1.tx_data  = dat[1][7:0];
  assign if2.tx_data  = dat[2][7:0];
  assign if3.tx_data  = dat[3][4:0];
  assign rdy[0] = if0.tx_ready;
  assign rdy[1] = if1.tx_ready;
  assign rdy[2] = if2.tx_ready;
  assign rdy[3] = if3.tx_ready;

  uart_tx_framer #(
    .DATA_W(8), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .baud_tick(baud_tick), .tx(if0.slave),
    .tx_out(txo[0]), .busy(bsy[0]),
    .frame_done(fd[0]), .bit_sel(bs[0])
  );

  uart_tx_framer #(
    .DATA_W(8), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .baud_tick(baud_tick), .tx(if1.slave),
    .tx_out(txo[1]), .busy(bsy[1]),
    .frame_done(fd[1]), .bit_sel(bs[1])
  );

  uart_tx_framer #(
    .DATA_W(8), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .baud_tick(baud_tick), .tx(if2.slave),
    .tx_out(txo[2]), .busy(bsy[2]),
    .frame_done(fd[2]), .bit_sel(bs[2])
  );

  uart_tx_framer #(
    .DATA_W(5), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(2)
  ) u3 (
    .clk(clk), .rst_n(rst_n),
    .baud_tick(baud_tick), .tx(if3.slave),
    .tx_out(txo[3]), .busy(bsy[3]),
    .frame_done(fd[3]), .bit_sel(bs[3])
  );

  int checks = 0;
  int fails  = 0;
  int last_load_len = 0;

  logic       exp_line[$];
  logic [1:0] exp_sel[$];

  // Frame as a list of (line level, bit kind), straight from the word.
  function automatic void build_model(
    input int d, input logic [8:0] w);
    int ones;
    exp_line.delete();
    exp_sel.delete();
    exp_line.push_back(1'b0);
    exp_sel.push_back(2'b00);
    ones = 0;
    for (int i = 0; i < c_dw[d]; i++) begin
      exp_line.push_back(w[i]);
      exp_sel.push_back(2'b01);
      ones += int'(w[i]);
    end
    if (c_pe[d] != 0) begin
      exp_line.push_back(1'((ones % 2) ^ c_po[d]));
      exp_sel.push_back(2'b10);
    end
    for (int s = 0; s < c_sb[d]; s++) begin
      exp_line.push_back(1'b1);
      exp_sel.push_back(2'b11);
    end
  endfunction

  // Called just after a negedge; returns just after a negedge.
  task automatic send(
    input int d, input logic [8:0] w_in,
    input bit hold, input logic [8:0] nxt,
    input int poke_bit, input int abort_bit);
    logic [8:0] w, mask;
    logic gl;
    logic [1:0] gs;
    int guard, len;
    bit bad;
    mask = 9'((1 << c_dw[d]) - 1);
    w = w_in & mask;
    build_model(d, w);
    dat[d] = w;
    vld[d] = 1'b1;
    guard = 0;
    while (!rdy[d] && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!rdy[d]) begin
      fails++;
      $display("FAIL accept_timeout dut%0d ready=%b want 1",
               d, rdy[d]);
      vld[d] = 1'b0;
      return;
    end
    @(posedge clk);
    len = 0;
    bad = 0;
    gl = 1'b1;
    gs = 2'b11;
    do begin
      @(negedge clk);
      if (len == 0) begin
        if (hold) dat[d] = nxt & mask;
        else vld[d] = 1'b0;
      end
      len++;
      if (!bad && (txo[d] !== 1'b1 ||
          bs[d] !== 2'b11 || bsy[d] !== 1'b1 ||
          rdy[d] !== 1'b0 || fd[d] !== 1'b0)) begin
        bad = 1;
        gl = txo[d];
        gs = bs[d];
      end
    end while (!baud_tick && len < 100);
    last_load_len = len;
    checks++;
    if (bad) begin
      fails++;
      $display("FAIL load_phase dut%0d line=%b sel=%b want line=1 sel=11 busy=1",
               d, gl, gs);
    end
    @(posedge clk);
    for (int k = 0; k < exp_line.size(); k++) begin
      len = 0;
      bad = 0;
      do begin
        @(negedge clk);
        if (k == abort_bit && len == 1) begin
          #2 rst_n = 1'b0;
          #1;
          checks++;
          if (txo[d] !== 1'b1 || bsy[d] !== 1'b0 ||
              rdy[d] !== 1'b1 || bs[d] !== 2'b11) begin
            fails++;
            $display("FAIL abort dut%0d line=%b busy=%b ready=%b sel=%b want 1 0 1 11",
                     d, txo[d], bsy[d], rdy[d], bs[d]);
          end
          vld[d] = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (k == poke_bit && len == 2) begin
          vld[d] = 1'b1;
          dat[d] = ~w & mask;
        end
        if (k == poke_bit && len == 3) begin
          checks++;
          if (rdy[d] !== 1'b0) begin
            fails++;
            $display("FAIL busy_ready dut%0d ready=%b want 0",
                     d, rdy[d]);
          end
          vld[d] = 1'b0;
          dat[d] = w;
        end
        len++;
        if (!bad && (txo[d] !== exp_line[k] ||
            bs[d] !== exp_sel[k] || bsy[d] !== 1'b1 ||
            fd[d] !== 1'b0)) begin
          bad = 1;
          gl = txo[d];
          gs = bs[d];
        end
      end while (!baud_tick && len < 100);
      checks++;
      if (bad) begin
        fails++;
        $display("FAIL frame_bit dut%0d word=%h bit%0d line=%b sel=%b want line=%b sel=%b",
                 d, w, k, gl, gs, exp_line[k], exp_sel[k]);
      end
      checks++;
      if (len != 16) begin
        fails++;
        $display("FAIL bit_len dut%0d bit%0d cycles=%0d want 16",
                 d, k, len);
      end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (fd[d] !== 1'b1 || rdy[d] !== 1'b1 ||
        bsy[d] !== 1'b0 || txo[d] !== 1'b1) begin
      fails++;
      $display("FAIL frame_end dut%0d done=%b ready=%b busy=%b line=%b want 1 1 0 1",
               d, fd[d], rdy[d], bsy[d], txo[d]);
    end
    if (!hold) begin
      @(negedge clk);
      checks++;
      if (fd[d] !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse dut%0d done=%b want 0",
                 d, fd[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks += 5;
      if (txo[i] !== 1'b1) begin
        fails++;
        $display("FAIL rst_line dut%0d got=%b want 1", i, txo[i]);
      end
      if (rdy[i] !== 1'b1) begin
        fails++;
        $display("FAIL rst_ready dut%0d got=%b want 1", i, rdy[i]);
      end
      if (bsy[i] !== 1'b0) begin
        fails++;
        $display("FAIL rst_busy dut%0d got=%b want 0", i, bsy[i]);
      end
      if (fd[i] !== 1'b0) begin
        fails++;
        $display("FAIL rst_done dut%0d got=%b want 0", i, fd[i]);
      end
      if (bs[i] !== 2'b11) begin
        fails++;
        $display("FAIL rst_sel dut%0d got=%b want 11", i, bs[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_8n1();
    send(0, 9'h0A5, 0, 0, -1, -1);
  endtask

  task automatic test_parity();
    send(1, 9'h007, 0, 0, -1, -1);
    send(2, 9'h007, 0, 0, -1, -1);
  endtask

  task automatic test_5n2();
    send(3, 9'h01F, 0, 0, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 4; d++) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        send(d, 9'($urandom), 0, 0, -1, -1);
      end
    end
  endtask

  task automatic test_back_to_back();
    while (!(baud_tick && rdy[0])) @(negedge clk);
    send(0, 9'h055, 1, 9'h0AA, -1, -1);
    send(0, 9'h0AA, 0, 0, -1, -1);
    while (!(baud_tick && rdy[1])) @(negedge clk);
    send(1, 9'($urandom), 0, 0, -1, -1);
    checks++;
    if (last_load_len != 16) begin
      fails++;
      $display("FAIL tick_accept load cycles=%0d want 16",
               last_load_len);
    end
  endtask

  task automatic test_busy_ignore();
    bit bad;
    send(1, 9'h0C3, 0, 0, 3, -1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bsy[1] !== 1'b0 || txo[1] !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      fails++;
      $display("FAIL ignored_word busy=%b line=%b want 0 1",
               bsy[1], txo[1]);
    end
  endtask

  task automatic test_reset_mid();
    send(0, 9'h03C, 0, 0, -1, 4);
    repeat (3) @(negedge clk);
    send(0, 9'h096, 0, 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_5n2();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
